// File: rtl/riscv_run_controller.sv
// Run controller around the RISC-V core: drives core reset, counts cycles,
// watches the signature output and latches sticky pass/fail/stall/timeout.
module riscv_run_controller #(
    parameter int                DATA_W        = 32,
    parameter int                CNT_W         = 16,
    parameter int                RESET_CYCLES  = 1,
    parameter int                MAX_CYCLES    = 500,
    parameter int                STABLE_CYCLES = 16,
    parameter logic [DATA_W-1:0] PASS_VALUE    = DATA_W'(32'h0000_0001),
    parameter logic [DATA_W-1:0] FAIL_VALUE    = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic [DATA_W-1:0] out,
    output logic              core_reset,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              stall,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [DATA_W-1:0] last_out
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
    localparam bit                STALL_EN  = (STABLE_CYCLES != 0);
    localparam logic [CNT_W-1:0]  STB_LAST  =
        STALL_EN ? CNT_W'(STABLE_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        DONE
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  stable_cnt;
    logic [DATA_W-1:0] prev_out;
    logic              prev_valid;

    logic same;
    logic is_pass;
    logic is_fail;
    logic is_stall;
    logic is_time;
    logic term;

    assign same     = prev_valid && (out == prev_out);
    assign is_pass  = (out == PASS_VALUE);
    assign is_fail  = (out == FAIL_VALUE);
    assign is_stall = STALL_EN && same && (stable_cnt == STB_LAST);
    assign is_time  = (cycle_count == CYC_LAST);
    assign term     = is_pass || is_fail || is_stall || is_time;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            core_reset  <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            stall       <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            last_out    <= '0;
            stable_cnt  <= '0;
            prev_out    <= '0;
            prev_valid  <= 1'b0;
        end else if (restart) begin
            // restart wins over any termination seen this cycle
            state       <= HOLD;
            hold_cnt    <= '0;
            core_reset  <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            stall       <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            stable_cnt  <= '0;
            prev_valid  <= 1'b0;
        end else begin
            unique case (state)
                HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HOLD_LAST) begin
                        state       <= RUN;
                        core_reset  <= 1'b0;
                        running     <= 1'b1;
                        cycle_count <= '0;
                        stable_cnt  <= '0;
                        prev_valid  <= 1'b0;
                    end
                end
                RUN: begin
                    cycle_count <= cycle_count + 1'b1;
                    prev_out    <= out;
                    prev_valid  <= 1'b1;
                    stable_cnt  <= same ? stable_cnt + 1'b1 : '0;
                    if (term) begin
                        state    <= DONE;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        last_out <= out;
                        pass     <= is_pass;
                        fail     <= !is_pass && is_fail;
                        stall    <= !is_pass && !is_fail && is_stall;
                        timeout  <= !is_pass && !is_fail && !is_stall;
                    end
                end
                DONE: begin
                    core_reset <= 1'b0;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule
